fetch_queue: RTL and testbench
==============================

# fetch_queue

In-order instruction queue between the fetch stage and instruction decode. It accepts fetched PC/instruction pairs from fetch and presents them to decode. Dequeue is gated by `id_en` from the startup controller, so fetch can prefill while decode is still held off after reset. A `flush` input empties the queue on redirects such as branch mispredicts and traps.

## Interface
- `DEPTH`, 4: number of entries; power of two, at least 2.
- `INSTR_WIDTH`, 32: instruction word width.
- `ADDR_WIDTH`, 32: PC width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `id_en`  in  1  decode enable from the startup controller; level-sensitive.
- `flush`  in  1  synchronous discard of all entries.
- `fetch_valid`  in  1  fetch offers an entry.
- `fetch_ready`  out  1  queue accepts an entry.
- `fetch_pc`  in  ADDR_WIDTH  PC of the offered instruction.
- `fetch_instr`  in  INSTR_WIDTH  offered instruction.
- `id_valid`  out  1  head entry is presented to decode.
- `id_ready`  in  1  decode consumes the presented entry.
- `id_pc`  out  ADDR_WIDTH  PC presented to decode.
- `id_instr`  out  INSTR_WIDTH  instruction presented to decode.
- `count`  out  $clog2(DEPTH)+1  number of stored entries.

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr` of width $clog2(DEPTH) and a registered `count`.
- Pointers wrap modulo DEPTH. Entries leave in strict FIFO order.
- `fetch_ready = (count != DEPTH) && !flush`. It depends only on registered state and `flush`, never on `id_ready`.
  - A full queue therefore does not accept an entry even when a dequeue happens in the same cycle.
- Enqueue happens when `fetch_valid && fetch_ready`: write at `wr_ptr`, then increment `wr_ptr`.
- `id_valid = id_en && !flush && (count != 0)`.
- Dequeue happens when `id_valid && id_ready`: increment `rd_ptr`.
- `id_pc`/`id_instr` always drive the entry at `rd_ptr`. Their values are meaningful only while `id_valid` is high.
- `count` next value:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged when both or neither occur.
- Enqueue is permitted while `id_en` is low (prefill). Once the queue is full, `fetch_ready` stays low until `id_en` rises and decode drains an entry.
- `flush`:
  - Enqueue and dequeue are suppressed in that cycle.
  - On the next edge, `wr_ptr`, `rd_ptr` and `count` all become 0.
  - Storage contents are left unchanged.
- `id_en` falling while entries are stored: `id_valid` drops in the same cycle and contents are retained.

## Timing
- Reset values, with `rst` asserted:
  - `count` = 0, pointers = 0, all storage = 0.
  - `id_valid` = 0; `id_pc` = 0; `id_instr` = 0.
  - `fetch_ready` = 1 unless `flush` is high.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. All in-flight entries are lost.
- Enqueue-to-`id_valid` latency is 1 cycle: an entry written at edge N is presentable in cycle N+1 if `id_en` is high.
- Throughput is 1 entry per cycle in steady state (count strictly between 0 and DEPTH, both sides valid/ready).
- `flush` and `rst` have no outstanding handshakes to complete; handshakes take effect only on the edge at which valid && ready holds.

## Configuration
- Macro: `QU_FETCH_QUEUE_BYPASS_EN`.
- Without the macro: behaviour is exactly as above, with a minimum 1-cycle latency.
- With the macro defined:
  - `id_valid = id_en && !flush && (count != 0 || fetch_valid)`.
  - When `count == 0`, `id_pc`/`id_instr` are driven combinationally from `fetch_pc`/`fetch_instr`.
  - If that presentation is consumed (`id_ready` high), the entry is not written and pointers and `count` are unchanged.
  - If it is not consumed, the entry is enqueued normally and appears from storage next cycle.
  - `fetch_ready` is unchanged.
  - Zero-cycle latency applies when the queue is empty.

## Test plan
- Prefill while decode is held off: reset, `id_en`=0, push 5 entries with PCs 0x0, 0x4, 0x8, 0xC, 0x10.
  - 4 are accepted, `count`=4, `fetch_ready`=0, `id_valid`=0.
  - Raise `id_en` with `id_ready`=1: PCs 0x0 to 0xC come out on 4 consecutive cycles, then 0x10 is accepted.
- Streaming: `id_en`=1, `fetch_valid` and `id_ready` held high for 20 cycles, PC incrementing by 4.
  - All 20 entries appear in order, one per cycle, with `count` at most 1 and no entry dropped or duplicated.
- Pointer wrap-around: alternate 3 enqueues and 3 dequeues for 10 rounds with DEPTH=4.
  - Ordering holds across the wrap and `count` returns to 0 after each round.
- Flush: 3 entries stored, pulse `flush` for 1 cycle while `fetch_valid`=1 and `id_ready`=1.
  - Neither side completes a handshake, `count`=0 next cycle, and the next enqueued PC 0x100 is the next one presented.
- Reset mid-operation: 2 entries stored, assert `rst` between clock edges.
  - `count`, `id_valid` and `id_pc` go to 0 before the next edge.
  - After `rst` is released, `fetch_ready`=1.
- Bypass, with `QU_FETCH_QUEUE_BYPASS_EN` defined: queue empty, `id_en`=1, `fetch_valid`=1 with PC 0x40, `id_ready`=1.
  - `id_valid`=1 and `id_pc`=0x40 in the same cycle, and `count` stays 0.
  - Repeat with `id_ready`=0: `count`=1 next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: in-order PC/instruction queue between fetch and decode.
// Circular buffer with a registered occupancy count. Decode presentation is
// gated by id_en so fetch can prefill while decode is held after reset.
// flush discards all entries on redirects; storage contents are kept.
// Optional zero-latency bypass of an empty queue: define QU_FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH       = 4,
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_en,
  input  logic                       flush,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [ADDR_WIDTH-1:0]      fetch_pc,
  input  logic [INSTR_WIDTH-1:0]     fetch_instr,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [ADDR_WIDTH-1:0]      id_pc,
  output logic [INSTR_WIDTH-1:0]     id_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic                   head_valid;
  logic                   enq;
  logic                   deq;

  assign head_valid  = (count != '0);
  // Full never accepts, even with a same-cycle dequeue, so fetch_ready is
  // independent of id_ready.
  assign fetch_ready = (count != CW'(DEPTH)) && !flush;

`ifdef QU_FETCH_QUEUE_BYPASS_EN
  logic bypass_take;

  // Empty queue forwards the fetch offer straight to decode.
  always_comb begin
    id_valid    = id_en && !flush && (head_valid || fetch_valid);
    id_pc       = head_valid ? pc_mem[rd_ptr]    : fetch_pc;
    id_instr    = head_valid ? instr_mem[rd_ptr] : fetch_instr;
    bypass_take = !head_valid && id_valid && id_ready;
    enq         = fetch_valid && fetch_ready && !bypass_take;
    deq         = head_valid && id_valid && id_ready;
  end
`else
  // Head of storage is always presented; id_valid qualifies it.
  always_comb begin
    id_valid = id_en && !flush && head_valid;
    id_pc    = pc_mem[rd_ptr];
    id_instr = instr_mem[rd_ptr];
    enq      = fetch_valid && fetch_ready;
    deq      = id_valid && id_ready;
  end
`endif

  // Entry storage; flush leaves contents in place, only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (enq) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= fetch_instr;
    end
  end

  // Pointers and occupancy; power-of-two depth makes the pointer wrap free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (DEPTH=4).
// Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
module tb_fetch_queue;

  localparam int DEPTH = 4;
`ifdef QU_FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_en = 1'b0;
  logic        flush = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_pc = '0;
  logic [31:0] fetch_instr = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [2:0]  count;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  fetch_queue #(.DEPTH(DEPTH), .INSTR_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .id_en(id_en), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    fetch_valid = v;
    fetch_pc    = pc;
    fetch_instr = instr_of(pc);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    #1 rst = 1'b0;
    tick();

    // prefill with decode held off
    id_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'(4 * i));
      #1 chk("prefill_ready", 32'(fetch_ready), 32'd1);
      tick();
    end
    offer(1'b1, 32'h10);
    #1;
    chk("prefill_count", 32'(count), 32'd4);
    chk("prefill_full_ready", 32'(fetch_ready), 32'd0);
    chk("prefill_id_valid", 32'(id_valid), 32'd0);
    tick();
    chk("prefill_hold_count", 32'(count), 32'd4);
    id_en = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("drain_valid", 32'(id_valid), 32'd1);
      chk("drain_pc", id_pc, 32'(4 * i));
      chk("drain_instr", id_instr, instr_of(32'(4 * i)));
      if (i == 0) chk("drain_full_ready", 32'(fetch_ready), 32'd0);
      if (i == 1) chk("drain_reopen_ready", 32'(fetch_ready), 32'd1);
      tick();
      if (i == 1) offer(1'b0, 32'h0);
    end
    #1;
    chk("drain_empty_valid", 32'(id_valid), 32'd0);
    chk("drain_empty_count", 32'(count), 32'd0);

    // streaming, one entry per cycle
    tick();
    for (int i = 0; i <= 20; i++) begin
      offer(i < 20, 32'h200 + 32'(4 * i));
      #1;
      if (i >= LAT && (i - LAT) < 20) begin
        chk("stream_valid", 32'(id_valid), 32'd1);
        chk("stream_pc", id_pc, 32'h200 + 32'(4 * (i - LAT)));
      end
      chk("stream_count_le1", 32'(count <= 3'd1), 32'd1);
      tick();
    end
    offer(1'b0, 32'h0);
    #1 chk("stream_end_count", 32'(count), 32'd0);
    tick();

    // pointer wrap: 3 in, 3 out, 10 rounds
    for (int r = 0; r < 10; r++) begin
      id_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        offer(1'b1, 32'h300 + 32'(12 * r + 4 * k));
        tick();
      end
      offer(1'b0, 32'h0);
      id_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        #1 chk("wrap_pc", id_pc, 32'h300 + 32'(12 * r + 4 * k));
        tick();
      end
      #1 chk("wrap_count", 32'(count), 32'd0);
    end

    // flush with both sides offering a handshake
    id_en = 1'b0;
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(1'b1, 32'h500 + 32'(4 * k));
      tick();
    end
    id_en = 1'b1;
    id_ready = 1'b1;
    flush = 1'b1;
    offer(1'b1, 32'h999);
    #1;
    chk("flush_fetch_ready", 32'(fetch_ready), 32'd0);
    chk("flush_id_valid", 32'(id_valid), 32'd0);
    chk("flush_pre_count", 32'(count), 32'd3);
    tick();
    flush = 1'b0;
    id_ready = 1'b0;
    offer(1'b1, 32'h100);
    #1 chk("flush_post_count", 32'(count), 32'd0);
    tick();
    offer(1'b0, 32'h0);
    #1;
    chk("flush_next_valid", 32'(id_valid), 32'd1);
    chk("flush_next_pc", id_pc, 32'h100);
    chk("flush_next_count", 32'(count), 32'd1);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    #1 chk("flush_drained", 32'(count), 32'd0);

    // asynchronous reset mid-operation
    tick();
    for (int k = 0; k < 2; k++) begin
      offer(1'b1, 32'h600 + 32'(4 * k));
      tick();
    end
    offer(1'b0, 32'h0);
    #1;
    chk("mid_pre_count", 32'(count), 32'd2);
    chk("mid_pre_pc", id_pc, 32'h600);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(id_valid), 32'd0);
    chk("mid_rst_pc", id_pc, 32'd0);
    rst = 1'b0;
    #1 chk("mid_rel_ready", 32'(fetch_ready), 32'd1);
    tick();

`ifdef QU_FETCH_QUEUE_BYPASS_EN
    // zero-latency bypass of an empty queue
    id_en = 1'b1;
    id_ready = 1'b1;
    offer(1'b1, 32'h40);
    #1;
    chk("byp_valid", 32'(id_valid), 32'd1);
    chk("byp_pc", id_pc, 32'h40);
    chk("byp_count", 32'(count), 32'd0);
    tick();
    chk("byp_taken_count", 32'(count), 32'd0);
    id_ready = 1'b0;
    #1;
    chk("byp_hold_valid", 32'(id_valid), 32'd1);
    chk("byp_hold_pc", id_pc, 32'h40);
    tick();
    offer(1'b0, 32'h0);
    #1;
    chk("byp_stored_count", 32'(count), 32'd1);
    chk("byp_stored_pc", id_pc, 32'h40);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
